alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle control front-end that drives the ALU's operand and opcode inputs and consumes its result and branch-condition outputs. Accepts one decoded RV32 instruction at a time through a valid/ready handshake and owns the PC register. Sequences each instruction class through one or two ALU cycles, then issues a register-file writeback and PC update. Sits between the decode/register-read stage and the register file; the ALU is instantiated alongside it, not inside it.

Parameters:
RESET_PC, 32'h0000_0000, value loaded into pc on reset
XLEN, 32, datapath width; only 32 is supported

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
inst_valid  in  1  instruction and operands are presented
inst_ready  out  1  high only in IDLE; an instruction is accepted when inst_valid && inst_ready
inst  in  32  raw instruction word; opcode/funct3/funct7/rd fields are decoded here
rs1_data  in  32  rs1 operand, sampled at accept
rs2_data  in  32  rs2 operand, sampled at accept
imm  in  32  sign-extended immediate, sampled at accept
alu_in_1  out  32  ALU operand A
alu_in_2  out  32  ALU operand B
alu_op  out  4  ALU opcode: 0 SUB, 1 ADD, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 EQ, 8 NE, 9 LT, 10 GE, 15 idle
alu_result  in  32  ALU result (zero for opcodes 7-10)
alu_bcond  in  1  ALU compare result (meaningful for opcodes 7-10 only)
pc  out  32  architectural PC register
rd_we  out  1  one-cycle register-file write strobe
rd_addr  out  5  destination register
rd_wdata  out  32  writeback data
done  out  1  one-cycle pulse on instruction retirement
illegal  out  1  qualifies done; the retired instruction was unsupported

Behaviour:
- Reset (sync, high): state=IDLE, pc=RESET_PC, rd_we=0, done=0, illegal=0, rd_addr=0, rd_wdata=0. Reset asserted mid-instruction abandons it: no writeback and no PC change beyond the reset value.
- IDLE drives alu_op=15 and alu_in_1=alu_in_2=0. Accept latches inst fields, operands, and imm.
- States: IDLE, EXEC, BR_CMP, BR_TGT, J_LINK, J_TGT, WB. WB always returns to IDLE, so there is one idle cycle between instructions.
- R-type (0110011) / I-ALU (0010011): IDLE→EXEC→WB. EXEC drives rs1, rs2 (or imm). Result is captured at the end of EXEC. WB: rd_we=1, done=1, pc+=4. Latency: accept at cycle T, done at T+2.
- Op mapping from funct3: 000→ADD, or SUB for R-type with funct7[5]=1; 111→AND; 110→OR; 100→XOR; 001→SLL; 101→SRL when funct7[5]=0. 101 with funct7[5]=1 (SRA), 010, and 011 are illegal.
- Shifts (op 5/6): alu_in_2 = {27'b0, operand[4:0]}, so only the 5-bit shamt reaches the ALU.
- Branch (1100011): IDLE→BR_CMP→BR_TGT→WB.
  - BR_CMP drives rs1/rs2 with funct3 000→7, 001→8, 100/110→9, 101/111→10, and latches alu_bcond into taken.
  - ALU ordering is unsigned for all four compare funct3 values; signed BLT/BGE is a known limitation.
  - Other funct3 values are illegal.
  - BR_TGT drives ADD(pc, imm). At the end of BR_TGT the next PC is alu_result if taken, else pc+4.
  - WB: done=1, rd_we=0, pc updated. Latency: T+3.
- JAL (1101111): IDLE→J_LINK→J_TGT→WB.
  - J_LINK: ADD(pc, 4), result latched as link.
  - J_TGT: ADD(pc, imm), result latched as target.
  - WB: rd_we=1, rd_wdata=link, pc=target, done=1. Latency: T+3.
- rd_addr=0: rd_we still pulses; the register file ignores x0.
- Illegal opcode or funct: IDLE→WB directly. WB: done=1, illegal=1, rd_we=0, pc+=4. Latency: T+1.
- PC arithmetic wraps modulo 2^32. The pc+4 incrementer is a dedicated adder.
- inst_valid held high during a busy period has no effect; the instruction is re-accepted only in IDLE.

Decomposition:
- Shared package alu_pkg: alu_op localparams 0-10 and 15, opcode constants (R, I-ALU, BRANCH, JAL), and state encoding.
- Sub-module alu_op_decode: combinational map from opcode/funct3/funct7[5] to {alu_op, is_shift, illegal}.

Test Plan:
- R-type ADD: rs1=5, rs2=7 → alu_op=1 in EXEC; at T+2 rd_we=1, rd_wdata=12, pc=RESET_PC+4.
- R-type SUB with funct7[5]=1: rs1=3, rs2=5 → rd_wdata=32'hFFFF_FFFE. SLLI: rs1=1, imm=32'h0000_0023 → alu_in_2=3, rd_wdata=8.
- BEQ taken: pc=0x100, rs1=rs2=9, imm=-8 → BR_CMP alu_op=7; at T+3 pc=0xF8, rd_we=0. BNE with equal operands → pc=0x104.
- JAL: pc=0x200, imm=0x40, rd=1 → at T+3 rd_wdata=0x204, pc=0x240.
- Illegal (opcode 0000011 or SRA) → done and illegal high at T+1, rd_we=0, pc+=4; inst_ready high at T+2.
- Reset asserted during BR_TGT → next cycle state IDLE, pc=RESET_PC, no done pulse; back-to-back ADDs afterwards retire every 3 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: ALU opcodes, RV32 major opcodes and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] AluSub  = 4'd0;
    localparam logic [3:0] AluAdd  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSll  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluEq   = 4'd7;
    localparam logic [3:0] AluNe   = 4'd8;
    localparam logic [3:0] AluLt   = 4'd9;
    localparam logic [3:0] AluGe   = 4'd10;
    localparam logic [3:0] AluIdle = 4'd15;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcIAlu   = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StBrCmp,
        StBrTgt,
        StJLink,
        StJTgt,
        StWb
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into an ALU opcode, shift flag and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op,
    output logic       is_shift,
    output logic       illegal
);

    always_comb begin
        alu_op   = AluIdle;
        is_shift = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OpcR, OpcIAlu: begin
                case (funct3)
                    3'b000: alu_op = (opcode == OpcR && funct7_5) ? AluSub : AluAdd;
                    3'b111: alu_op = AluAnd;
                    3'b110: alu_op = AluOr;
                    3'b100: alu_op = AluXor;
                    3'b001: begin
                        alu_op   = AluSll;
                        is_shift = 1'b1;
                    end
                    3'b101: begin
                        // Arithmetic right shift is not supported by the ALU.
                        if (funct7_5) begin
                            illegal = 1'b1;
                        end else begin
                            alu_op   = AluSrl;
                            is_shift = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OpcBranch: begin
                case (funct3)
                    3'b000:         alu_op = AluEq;
                    3'b001:         alu_op = AluNe;
                    3'b100, 3'b110: alu_op = AluLt;
                    3'b101, 3'b111: alu_op = AluGe;
                    default:        illegal = 1'b1;
                endcase
            end
            OpcJal:  alu_op = AluAdd;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control front-end: accepts one decoded instruction, steps the external ALU through
// one or two cycles, then retires with a register-file writeback and PC update.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_in_1,
    output logic [XLEN-1:0] alu_in_2,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_bcond,
    output logic [XLEN-1:0] pc,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            done,
    output logic            illegal
);

    state_t          state;
    logic [3:0]      op_q;
    logic            shift_q;
    logic            use_imm_q;
    logic            taken_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] link_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] operand_b;

    logic [3:0]      dec_op;
    logic            dec_shift;
    logic            dec_illegal;

    alu_op_decode u_decode (
        .opcode   (inst[6:0]),
        .funct3   (inst[14:12]),
        .funct7_5 (inst[30]),
        .alu_op   (dec_op),
        .is_shift (dec_shift),
        .illegal  (dec_illegal)
    );

    assign pc_plus4   = pc + XLEN'(4);
    assign inst_ready = (state == StIdle);
    assign operand_b  = use_imm_q ? imm_q : rs2_q;

    // ALU drive is a pure decode of registered state, so it is stable for the whole cycle.
    always_comb begin
        alu_in_1 = '0;
        alu_in_2 = '0;
        alu_op   = AluIdle;
        case (state)
            StExec: begin
                alu_in_1 = rs1_q;
                alu_in_2 = shift_q ? XLEN'(operand_b[4:0]) : operand_b;
                alu_op   = op_q;
            end
            StBrCmp: begin
                alu_in_1 = rs1_q;
                alu_in_2 = rs2_q;
                alu_op   = op_q;
            end
            StBrTgt, StJTgt: begin
                alu_in_1 = pc;
                alu_in_2 = imm_q;
                alu_op   = AluAdd;
            end
            StJLink: begin
                alu_in_1 = pc;
                alu_in_2 = XLEN'(4);
                alu_op   = AluAdd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            pc        <= RESET_PC;
            rd_we     <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            rd_addr   <= '0;
            rd_wdata  <= '0;
            op_q      <= AluIdle;
            shift_q   <= 1'b0;
            use_imm_q <= 1'b0;
            taken_q   <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            link_q    <= '0;
        end else begin
            done    <= 1'b0;
            rd_we   <= 1'b0;
            illegal <= 1'b0;
            case (state)
                StIdle: begin
                    if (inst_valid) begin
                        rs1_q     <= rs1_data;
                        rs2_q     <= rs2_data;
                        imm_q     <= imm;
                        op_q      <= dec_op;
                        shift_q   <= dec_shift;
                        use_imm_q <= (inst[6:0] == OpcIAlu);
                        rd_addr   <= inst[11:7];
                        if (dec_illegal) begin
                            pc      <= pc_plus4;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            state   <= StWb;
                        end else if (inst[6:0] == OpcBranch) begin
                            state <= StBrCmp;
                        end else if (inst[6:0] == OpcJal) begin
                            state <= StJLink;
                        end else begin
                            state <= StExec;
                        end
                    end
                end
                StExec: begin
                    rd_wdata <= alu_result;
                    rd_we    <= 1'b1;
                    done     <= 1'b1;
                    pc       <= pc_plus4;
                    state    <= StWb;
                end
                StBrCmp: begin
                    taken_q <= alu_bcond;
                    state   <= StBrTgt;
                end
                StBrTgt: begin
                    pc    <= taken_q ? alu_result : pc_plus4;
                    done  <= 1'b1;
                    state <= StWb;
                end
                StJLink: begin
                    link_q <= alu_result;
                    state  <= StJTgt;
                end
                StJTgt: begin
                    pc       <= alu_result;
                    rd_wdata <= link_q;
                    rd_we    <= 1'b1;
                    done     <= 1'b1;
                    state    <= StWb;
                end
                StWb:    state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
